// File: rtl/bcd_countdown_timer.sv
// BCD MM:SS countdown timer: decrements once per tick through a borrow chain
// and pulses done for one cycle when the count reaches 00:00.
module bcd_countdown_timer #(
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] min_in_i,
  input  logic [7:0] sec_in_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       tick_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       running_o,
  output logic       done_o
);

  localparam logic [3:0] MaxMinTens = 4'(MAX_MIN_TENS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  min_q;
  logic [7:0]  sec_q;
  logic        running_q;
  logic        done_q;

  logic [15:0] load_val_s;
  logic [15:0] dec_val_s;
  logic        at_one_s;
  logic        at_zero_s;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second decrement of a legal, non-zero {mt,mu,st,su} BCD count.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    logic       b0, b1, b2;
    {mt, mu, st, su} = v;
    b0 = (su == 4'd0);
    b1 = b0 && (st == 4'd0);
    b2 = b1 && (mu == 4'd0);
    su = b0 ? 4'd9 : su - 4'd1;
    st = b0 ? ((st == 4'd0) ? 4'd5 : st - 4'd1) : st;
    mu = b1 ? ((mu == 4'd0) ? 4'd9 : mu - 4'd1) : mu;
    mt = b2 ? mt - 4'd1 : mt;
    return {mt, mu, st, su};
  endfunction

  // Clamped load value, decremented count and terminal-count detects.
  always_comb begin
    load_val_s = {clamp_digit(min_in_i[7:4], MaxMinTens), clamp_digit(min_in_i[3:0], 4'd9),
                  clamp_digit(sec_in_i[7:4], 4'd5), clamp_digit(sec_in_i[3:0], 4'd9)};
    dec_val_s  = bcd_dec({min_q, sec_q});
    at_one_s   = ({min_q, sec_q} == 16'h0001);
    at_zero_s  = ({min_q, sec_q} == 16'h0000);
  end

  // Control FSM with registered count, running and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        {min_q, sec_q} <= load_val_s;
        state_q        <= IDLE;
        running_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // pause outranks start, so a simultaneous pause keeps us idle
            if (!pause_i && start_i) begin
              if (at_zero_s) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= RUN;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pause_i) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick_i) begin
              {min_q, sec_q} <= dec_val_s;
              if (at_one_s) begin
                state_q   <= DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (!pause_i && start_i) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min_o     = min_q;
  assign sec_o     = sec_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed plan plus random traffic, checked
// against a model that keeps the count as plain total seconds.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] min_in_i = 8'h00;
  logic [7:0] sec_in_i = 8'h00;
  logic       start_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic       running_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 pause, 3 done
  int m_secs  = 0;
  int m_state = 0;
  bit m_done  = 1'b0;
  int done_cnt = 0;

  bcd_countdown_timer dut (
    .clk(clk), .rst(rst), .load_i(load_i), .min_in_i(min_in_i), .sec_in_i(sec_in_i),
    .start_i(start_i), .pause_i(pause_i), .tick_i(tick_i),
    .min_o(min_o), .sec_o(sec_o), .running_o(running_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic int lim(input int d, input int l);
    return (d > l) ? l : d;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic st, input logic pa,
                      input logic tk, input logic [7:0] mi, input logic [7:0] si);
    rst = r; load_i = ld; start_i = st; pause_i = pa; tick_i = tk;
    min_in_i = mi; sec_in_i = si;
    @(posedge clk);
    m_done = 1'b0;
    if (r) begin
      m_secs = 0; m_state = 0;
    end else if (ld) begin
      m_secs = (lim(int'(mi[7:4]), 9) * 10 + lim(int'(mi[3:0]), 9)) * 60
             + lim(int'(si[7:4]), 5) * 10 + lim(int'(si[3:0]), 9);
      m_state = 0;
    end else begin
      case (m_state)
        0: if (!pa && st) begin
             if (m_secs == 0) begin m_state = 3; m_done = 1'b1; end
             else m_state = 1;
           end
        1: if (pa) m_state = 2;
           else if (tk) begin
             m_secs = m_secs - 1;
             if (m_secs == 0) begin m_state = 3; m_done = 1'b1; end
           end
        2: if (!pa && st) m_state = 1;
        default: ;
      endcase
    end
    #1;
    if (done_o) done_cnt++;
    chk("min", min_o, to_bcd(m_secs / 60));
    chk("sec", sec_o, to_bcd(m_secs % 60));
    chk("running", {7'd0, running_o}, {7'd0, m_state == 1});
    chk("done", {7'd0, done_o}, {7'd0, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic load(input logic [7:0] mi, input logic [7:0] si);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mi, si);
  endtask

  task automatic start();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  initial begin
    // reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rst_min", min_o, 8'h00);
    chk("rst_run", {7'd0, running_o}, 8'h00);

    // 01:05 countdown with spaced ticks
    load(8'h01, 8'h05);
    start();
    chk("start_running", {7'd0, running_o}, 8'h01);
    done_cnt = 0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 6) chk("wrap_sec", sec_o, 8'h59);
      if (k == 65) begin
        chk("end_count", {min_o, sec_o} == 16'h0000 ? 8'h01 : 8'h00, 8'h01);
        chk("end_done", {7'd0, done_o}, 8'h01);
        chk("end_running", {7'd0, running_o}, 8'h00);
      end
      idle(2);
    end
    chk("one_done_pulse", 8'(done_cnt), 8'h01);

    // full borrow chain
    load(8'h10, 8'h00);
    start();
    tick();
    chk("borrow_min", min_o, 8'h09);
    chk("borrow_sec", sec_o, 8'h59);

    // clamping, and start at 00:00
    load(8'h0A, 8'h7C);
    chk("clamp_min", min_o, 8'h09);
    chk("clamp_sec", sec_o, 8'h7C > 8'h59 ? 8'h59 : 8'h00);
    load(8'h00, 8'h00);
    done_cnt = 0;
    start();
    chk("zero_start_done", {7'd0, done_o}, 8'h01);
    start();
    start();
    tick();
    chk("zero_done_once", 8'(done_cnt), 8'h01);

    // pause with same-cycle tick
    load(8'h00, 8'h30);
    start();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    chk("pause_sec", sec_o, 8'h30);
    tick();
    tick();
    chk("paused_hold", sec_o, 8'h30);
    start();
    tick();
    chk("resume_sec", sec_o, 8'h29);

    // load beats tick at 00:01, then reset mid-count
    load(8'h00, 8'h01);
    start();
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h00);
    chk("load_tick_min", min_o, 8'h02);
    chk("load_tick_nodone", 8'(done_cnt), 8'h00);
    load(8'h01, 8'h15);
    start();
    tick();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("rst_mid_sec", sec_o, 8'h00);

    // back-to-back ticks from 00:03
    load(8'h00, 8'h03);
    start();
    tick(); chk("b2b_2", sec_o, 8'h02);
    tick(); chk("b2b_1", sec_o, 8'h01);
    tick(); chk("b2b_0_done", {7'd0, done_o}, 8'h01);
    tick(); chk("b2b_done_clear", {7'd0, done_o}, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2)),
           8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

BCD minutes:seconds countdown timer that decrements once per `tick` enable pulse and raises a one-cycle `done` pulse when it reaches 00:00. It complements the team's free-running up-counters. Instead of counting up and signalling carry, it counts down through a borrow chain:

- seconds units wrap 0→9;
- seconds tens wrap 0→5 (mod-6);
- minutes units wrap 0→9.

It sits behind the prescaler that produces the 1 Hz `tick`. It feeds the display digit drivers and the alarm logic.

## Interface
- `MAX_MIN_TENS`, default 9: largest legal minutes-tens digit. Minutes range 00..(MAX_MIN_TENS·10+9).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: load `min_in`/`sec_in` into the count and go to IDLE.
- `min_in` in 8: BCD minutes, [7:4] tens, [3:0] units.
- `sec_in` in 8: BCD seconds, [7:4] tens (0..5), [3:0] units.
- `start` in 1: begin or resume counting.
- `pause` in 1: suspend counting.
- `tick` in 1: one-cycle count enable; decrement by one second.
- `min` out 8: current BCD minutes, registered.
- `sec` out 8: current BCD seconds, registered.
- `running` out 1: high while in RUN, registered.
- `done` out 1: one-cycle pulse on reaching 00:00, registered.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE, `min`=8'h00, `sec`=8'h00, `running`=0, `done`=0.
- Priority in every state: `rst` > `load` > `pause` > `start` > `tick`.
- `load` (any state): count ← clamped inputs, state ← IDLE, `done` ← 0.
- Load clamping, per field:
  - sec tens >5 → 5;
  - any units digit >9 → 9;
  - min tens >MAX_MIN_TENS → MAX_MIN_TENS.
- IDLE:
  - `start` with count ≠ 00:00 → RUN.
  - `start` with count = 00:00 → DONE, and `done` pulses.
  - `tick` is ignored.
- RUN:
  - `pause` → PAUSE, and a same-cycle `tick` is dropped.
  - Otherwise `tick` decrements the count.
  - If the pre-decrement count is 00:01, the count becomes 00:00, state → DONE, and `done` pulses.
  - `start` in RUN has no effect.
- PAUSE:
  - Count holds.
  - `tick` is ignored.
  - `start` → RUN.
- DONE:
  - Count holds 00:00.
  - `start`, `pause` and `tick` are ignored.
  - Only `load` or `rst` leave DONE. No second `done` pulse without a new load.
- Decrement borrow chain, evaluated in one cycle:
  - sec units: if ≠0, −1; else →9 and borrow.
  - sec tens on borrow: if ≠0, −1; else →5 and borrow.
  - min units on borrow: if ≠0, −1; else →9 and borrow.
  - min tens on borrow: −1. It is never 0 here, because 00:00 is unreachable from RUN.
- Digits are always legal BCD. No intermediate value is ever visible.

## Timing
- Every output is registered; nothing depends combinationally on an input.
- `start` sampled at edge N → `running`=1 from N. A `tick` sampled at the same edge N is ignored, because the state was not yet RUN.
- `tick` sampled in RUN at edge N → new count visible after N (1-cycle latency).
- Final tick at edge N → `min`/`sec` = 00:00, `running`=0 and `done`=1, all after N. `done` returns to 0 after N+1.
- `pause` sampled at edge N → `running`=0 after N, and the count equals its pre-N value.
- `load` at the same edge as `tick` or `start` → load wins, state IDLE, count = clamped load value.
- `rst` mid-count → all outputs take reset values after that edge; an in-flight `done` is cancelled.
- Back-to-back `tick` (every cycle) is legal. The counter decrements once per cycle with no skipped values.

## Test plan
- Reset, then load 8'h01/8'h05, start, then 65 ticks spaced 3 cycles apart. Required:
  - `sec` sequence 05,04..00,59,58..;
  - count reaches 00:00 on the 65th tick;
  - exactly one `done` pulse, `running` falling on the same cycle.
- Load 8'h10/8'h00, start, one tick → 09:59. Checks the full borrow chain through all four digits.
- Load min 8'h0A, sec 8'h7C → count 09:59 (clamping). Load 00:00 then start → `done` pulses once one cycle later, state DONE, and further starts produce no pulse.
- RUN at 00:30: assert `pause` together with `tick` → count stays 00:30 and `running`=0. Ticks while paused → no change. `start` then tick → 00:29.
- RUN at 00:01: assert `load` (02:00) together with `tick` → count 02:00, IDLE, no `done`. Then `rst` during a later RUN at 01:15 → all outputs 0 the next cycle.
- Continuous `tick` every cycle from 00:03 → 00:02, 00:01, 00:00 on consecutive cycles, with `done` high for exactly the one cycle after 00:00 is reached.
